// File: rtl/fmap_pingpong_if.sv
// Producer/consumer port bundle for the ping-pong feature-map buffer.
// Master drives writes/reads, slave is the buffer.
interface fmap_pingpong_if #(
    parameter int LANE_W = 16,
    parameter int CH     = 16,
    parameter int DEPTH  = 128,
    parameter int AW     = $clog2(DEPTH)
);
    logic                 wr_en;
    logic [CH-1:0]        wr_lane_en;
    logic [AW-1:0]        wr_addr;
    logic [CH*LANE_W-1:0] wr_data;
    logic                 wr_done;
    logic                 wr_ready;
    logic                 wr_bank;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [CH*LANE_W-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_done;
    logic                 rd_ready;
    logic                 rd_bank;
    logic [1:0]           full_cnt;
    logic [2:0]           err;

    modport master (
        output wr_en, wr_lane_en, wr_addr, wr_data, wr_done,
        output rd_en, rd_addr, rd_done,
        input  wr_ready, wr_bank, rd_data, rd_valid,
        input  rd_ready, rd_bank, full_cnt, err
    );

    modport slave (
        input  wr_en, wr_lane_en, wr_addr, wr_data, wr_done,
        input  rd_en, rd_addr, rd_done,
        output wr_ready, wr_bank, rd_data, rd_valid,
        output rd_ready, rd_bank, full_cnt, err
    );
endinterface

// File: rtl/fmap_pingpong_ram.sv
// Two-bank ping-pong feature-map buffer with per-lane write enables.
// Bank ownership moves between writer and reader via done/ready pulses.
module fmap_pingpong_ram #(
    parameter int LANE_W = 16,
    parameter int CH     = 16,
    parameter int DEPTH  = 128,
    parameter int AW     = $clog2(DEPTH)
) (
    input logic            clk,
    input logic            rst,
    fmap_pingpong_if.slave bus
);
    localparam int W = CH * LANE_W;

    logic [W-1:0] mem [2][DEPTH];

    logic [1:0] full;
    logic       wsel;
    logic       rsel;
    logic [2:0] err_q;
    logic       rd_valid_q;
    logic [W-1:0] rd_data_q;

    logic wr_ready;
    logic rd_ready;
    logic wa_ok;
    logic ra_ok;
    logic wr_ok;
    logic rd_ok;
    logic commit;
    logic release_b;
    logic [2:0] err_set;

    assign wr_ready  = !full[wsel];
    assign rd_ready  = full[rsel];
    assign wa_ok     = int'({1'b0, bus.wr_addr}) < DEPTH;
    assign ra_ok     = int'({1'b0, bus.rd_addr}) < DEPTH;
    assign wr_ok     = bus.wr_en && wr_ready && wa_ok;
    assign rd_ok     = bus.rd_en && rd_ready && ra_ok;
    assign commit    = bus.wr_done && wr_ready;
    assign release_b = bus.rd_done && rd_ready;

    assign err_set[0] = (bus.wr_en || bus.wr_done) && !wr_ready;
    assign err_set[1] = (bus.rd_en || bus.rd_done) && !rd_ready;
    assign err_set[2] = (bus.wr_en && !wa_ok) || (bus.rd_en && !ra_ok);

    assign bus.wr_ready = wr_ready;
    assign bus.rd_ready = rd_ready;
    assign bus.wr_bank  = wsel;
    assign bus.rd_bank  = rsel;
    assign bus.full_cnt = {1'b0, full[0]} + {1'b0, full[1]};
    assign bus.err      = err_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

    // RAM array carries no reset so it maps onto block memory
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < CH; i++) begin
                if (bus.wr_lane_en[i])
                    mem[wsel][bus.wr_addr][i*LANE_W +: LANE_W]
                        <= bus.wr_data[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full       <= 2'b00;
            wsel       <= 1'b0;
            rsel       <= 1'b0;
            err_q      <= 3'b000;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            // commit and release always hit different banks
            if (commit) begin
                full[wsel] <= 1'b1;
                wsel       <= ~wsel;
            end
            if (release_b) begin
                full[rsel] <= 1'b0;
                rsel       <= ~rsel;
            end
            rd_valid_q <= rd_ok;
            if (rd_ok)
                rd_data_q <= mem[rsel][bus.rd_addr];
            err_q <= err_q | err_set;
        end
    end
endmodule
